uart_transmitter: RTL and testbench

Serial UART transmitter paired with the `receiver` block in `top_communication`. Accepts a parallel byte through a start/ready handshake and serialises it on `tx` as start bit, LSB-first data bits, optional parity bit and stop bit(s). Bit timing comes from the shared baud-rate generator's 16x oversampling `tick`. Idle line level is high.

---
 rtl/uart_transmitter.sv | 168 ++++++++++++++++
 tb/tb_uart_transmitter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
//============================================================================
// Module   : uart_transmitter
// Brief    : UART serialiser (start, LSB-first data, stop bits) paced by a
//            16x oversampling tick. Define UART_TX_PARITY_EN for even parity.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module uart_transmitter #(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  tick,
    input  logic                  tx_start,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  tx,
    output logic                  tx_ready,
    output logic                  tx_done
);

    localparam int                     c_bit_cnt_w = $clog2(DATA_WIDTH) + 1;
    localparam logic [c_bit_cnt_w-1:0] c_bit_last  = c_bit_cnt_w'(DATA_WIDTH - 1);
    localparam logic                   c_stop_last = 1'(STOP_BITS - 1);
    localparam logic [3:0]             c_tick_last = 4'd15;

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_start  = 3'd1;
    localparam logic [2:0] c_st_data   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] c_st_parity = 3'd3;
`endif
    localparam logic [2:0] c_st_stop   = 3'd4;

    logic [2:0]             state_q,    state_d;
    logic [3:0]             tick_cnt_q, tick_cnt_d;
    logic [c_bit_cnt_w-1:0] bit_cnt_q,  bit_cnt_d;
    logic [DATA_WIDTH-1:0]  shift_q,    shift_d;
    logic                   stop_cnt_q, stop_cnt_d;
    logic                   tx_q,       tx_d;
    logic                   tx_done_q,  tx_done_d;
`ifdef UART_TX_PARITY_EN
    logic                   parity_q,   parity_d;
`endif
    logic                   tick_wrap;

    assign tick_wrap = tick && (tick_cnt_q == c_tick_last);

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        stop_cnt_d = stop_cnt_q;
        tx_done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        case (state_q)
            c_st_idle: begin
                // Ticks in IDLE are ignored, so a tick on the acceptance edge never counts.
                if (tx_start) begin
                    shift_d    = data_in;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
`ifdef UART_TX_PARITY_EN
                    parity_d   = ^data_in;
`endif
                    state_d    = c_st_start;
                end
            end
            c_st_start: begin
                if (tick_wrap) begin
                    tick_cnt_d = '0;
                    state_d    = c_st_data;
                end else if (tick) begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                end
            end
            c_st_data: begin
                if (tick_wrap) begin
                    shift_d    = shift_q >> 1;
                    tick_cnt_d = '0;
                    if (bit_cnt_q == c_bit_last) begin
`ifdef UART_TX_PARITY_EN
                        state_d = c_st_parity;
`else
                        state_d = c_st_stop;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + c_bit_cnt_w'(1);
                    end
                end else if (tick) begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            c_st_parity: begin
                if (tick_wrap) begin
                    tick_cnt_d = '0;
                    state_d    = c_st_stop;
                end else if (tick) begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                end
            end
`endif
            c_st_stop: begin
                if (tick_wrap) begin
                    tick_cnt_d = '0;
                    if (stop_cnt_q == c_stop_last) begin
                        tx_done_d = 1'b1;
                        state_d   = c_st_idle;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end else if (tick) begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                end
            end
            default: state_d = c_st_idle;
        endcase

        // Line level follows the next state so tx changes on the same edge as the state.
        case (state_d)
            c_st_start:  tx_d = 1'b0;
            c_st_data:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            c_st_parity: tx_d = parity_d;
`endif
            default:     tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q    <= c_st_idle;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
            tx_done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
            tx_done_q  <= tx_done_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign tx       = tx_q;
    assign tx_done  = tx_done_q;
    assign tx_ready = (state_q == c_st_idle);

endmodule

`default_nettype wire

// File: tb/tb_uart_transmitter.sv
//============================================================================
// Module   : tb_uart_transmitter
// Brief    : Self-checking bench: frame-vector reference model compared every
//            cycle, plus directed literal checks. Honours UART_TX_PARITY_EN.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_uart_transmitter;

    localparam int DW = 8;
    localparam int SB = 1;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NBITS = 1 + DW + PAR + SB;

    logic          clk      = 1'b0;
    logic          arst_n   = 1'b0;
    logic          tick     = 1'b0;
    logic          tx_start = 1'b0;
    logic [DW-1:0] data_in  = '0;
    logic          tx;
    logic          tx_ready;
    logic          tx_done;

    uart_transmitter #(.DATA_WIDTH(DW), .STOP_BITS(SB)) dut (
        .clk      (clk),
        .arst_n   (arst_n),
        .tick     (tick),
        .tx_start (tx_start),
        .data_in  (data_in),
        .tx       (tx),
        .tx_ready (tx_ready),
        .tx_done  (tx_done)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: a frame is a bit vector; each entry lasts 16 ticks.
    function automatic logic [15:0] frame_of(input logic [DW-1:0] d);
        logic [15:0] f;
        f    = '1;
        f[0] = 1'b0;
        for (int i = 0; i < DW; i++) f[1+i] = d[i];
        if (PAR == 1) f[1+DW] = ^d;
        return f;
    endfunction

    logic [15:0] m_bits = '1;
    int          m_idx  = 0;
    int          m_cnt  = 0;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;

    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_idx  <= 0;
            m_cnt  <= 0;
        end else begin
            m_done <= 1'b0;
            if (!m_busy) begin
                if (tx_start) begin
                    m_bits <= frame_of(data_in);
                    m_busy <= 1'b1;
                    m_idx  <= 0;
                    m_cnt  <= 0;
                end
            end else if (tick) begin
                if (m_cnt == 15) begin
                    m_cnt <= 0;
                    if (m_idx == NBITS - 1) begin
                        m_busy <= 1'b0;
                        m_done <= 1'b1;
                    end else begin
                        m_idx <= m_idx + 1;
                    end
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end
        end
    end

    logic chk_en = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_tx", int'(tx), m_busy ? int'(m_bits[m_idx]) : 1);
            check("model_tx_ready", int'(tx_ready), int'(!m_busy));
            check("model_tx_done", int'(tx_done), int'(m_done));
        end
    end

    // 0: tick every clk, 1: tick every 4th clk, 2: random tick
    int tick_mode = 0;
    int tick_ph   = 0;
    initial forever begin
        @(posedge clk);
        #1;
        case (tick_mode)
            0: tick = 1'b1;
            1: begin
                tick    = (tick_ph == 0);
                tick_ph = (tick_ph + 1) % 4;
            end
            default: tick = ($urandom_range(0, 2) == 0);
        endcase
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    logic txlog [0:1023];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // txlog[n] is tx in the n-th cycle after the acceptance cycle; n returns the tx_done cycle.
    task automatic send_log(input logic [DW-1:0] d, output int n);
        bit got;
        got = 1'b0;
        step();
        tx_start = 1'b1;
        data_in  = d;
        step();
        tx_start = 1'b0;
        data_in  = DW'($urandom);
        n = 0;
        while (!got && n < 1000) begin
            @(negedge clk);
            n++;
            txlog[n] = tx;
            got = tx_done;
        end
        check("frame_completes", int'(got), 1);
    endtask

    task automatic wait_done(input string name, input int limit);
        bit got;
        int cnt;
        got = 1'b0;
        cnt = 0;
        while (!got && cnt < limit) begin
            @(negedge clk);
            cnt++;
            got = tx_done;
        end
        check(name, int'(got), 1);
    endtask

    initial begin
        int         n;
        int         i0;
        int         idle;
        int         cnt;
        bit         got;
        logic [8:0] pat55;
        logic [7:0] pat_a5;

        repeat (3) @(negedge clk);
        check("reset_tx", int'(tx), 1);
        check("reset_tx_ready", int'(tx_ready), 1);
        check("reset_tx_done", int'(tx_done), 0);
        chk_en = 1'b1;
        step();
        arst_n = 1'b1;
        repeat (3) step();

        // 0x55, tick every clk: start, 1,0,1,0,1,0,1,0, stop; 16 clks per bit
        tick_mode = 0;
        send_log(8'h55, n);
        check("frame_clks_55", n, (PAR == 1) ? 177 : 161);
        pat55 = 9'b010101010;
        for (int k = 0; k < 9; k++) begin
            check("bit55_first_clk", int'(txlog[1+16*k]), int'(pat55[k]));
            check("bit55_last_clk", int'(txlog[16+16*k]), int'(pat55[k]));
        end
`ifdef UART_TX_PARITY_EN
        check("bit55_parity", int'(txlog[1+16*9+8]), 0);
`endif
        check("bit55_stop", int'(txlog[1+16*(9+PAR)+8]), 1);

        // 0xA5, tick every 4 clks: data bits 64 clks each, LSB-first 1,0,1,0,0,1,0,1
        tick_mode = 1;
        send_log(8'hA5, n);
        i0 = 0;
        for (int i = 1; i <= n; i++) begin
            if (i0 == 0 && txlog[i] == 1'b1) i0 = i;
        end
        check("a5_start_len_in_range", int'((i0 - 1) >= 61 && (i0 - 1) <= 64), 1);
        if (i0 == 0) i0 = 1;
        pat_a5 = 8'b1010_0101;
        for (int k = 0; k < 8; k++) begin
            check("a5_bit_first_clk", int'(txlog[i0+64*k]), int'(pat_a5[k]));
            check("a5_bit_last_clk", int'(txlog[i0+64*k+63]), int'(pat_a5[k]));
        end
        check("a5_stop", int'(txlog[i0+64*(8+PAR)+32]), 1);

        // Back-to-back with tx_start held; data_in changes during frame 1
        tick_mode = 0;
        step();
        tx_start = 1'b1;
        data_in  = 8'h0F;
        repeat (5) step();
        data_in  = 8'hF0;
        wait_done("b2b_frame1_done", 400);
        check("b2b_gap_tx_high", int'(tx), 1);
        check("b2b_gap_ready", int'(tx_ready), 1);
        @(negedge clk);
        check("b2b_restart_tx_low", int'(tx), 0);
        check("b2b_restart_busy", int'(tx_ready), 0);
        step();
        tx_start = 1'b0;
        wait_done("b2b_frame2_done", 400);

        // tx_start pulsed mid-frame is ignored, no second frame
        step();
        tx_start = 1'b1;
        data_in  = 8'h3C;
        step();
        tx_start = 1'b0;
        repeat (50) step();
        tx_start = 1'b1;
        data_in  = 8'hFF;
        step();
        tx_start = 1'b0;
        wait_done("midframe_done", 400);
        idle = 0;
        repeat (40) begin
            @(negedge clk);
            if (tx_ready && tx && !tx_done) idle++;
        end
        check("midframe_no_second_frame", idle, 40);

        // Asynchronous reset during data bit 3 of 0x00
        step();
        tx_start = 1'b1;
        data_in  = 8'h00;
        step();
        tx_start = 1'b0;
        repeat (71) step();
        arst_n = 1'b0;
        #1;
        check("arst_tx_immediate", int'(tx), 1);
        check("arst_ready_immediate", int'(tx_ready), 1);
        check("arst_done_low", int'(tx_done), 0);
        repeat (3) begin
            @(negedge clk);
            check("arst_no_done_pulse", int'(tx_done), 0);
        end
        step();
        arst_n = 1'b1;
        send_log(8'h81, n);
        check("after_rst_frame_clks", n, (PAR == 1) ? 177 : 161);
        check("after_rst_bit0", int'(txlog[1+16*1+8]), 1);
        check("after_rst_bit1", int'(txlog[1+16*2+8]), 0);
        check("after_rst_bit7", int'(txlog[1+16*8+8]), 1);

`ifdef UART_TX_PARITY_EN
        send_log(8'h07, n);
        check("par07_bit", int'(txlog[1+16*9+8]), 1);
        check("par07_frame_clks", n, 177);
        send_log(8'h03, n);
        check("par03_bit", int'(txlog[1+16*9+8]), 0);
`endif

        // Randomized traffic with random tick pacing
        tick_mode = 2;
        repeat (8000) begin
            step();
            tx_start = ($urandom_range(0, 3) == 0);
            data_in  = DW'($urandom);
        end
        step();
        tx_start = 1'b0;
        got = 1'b0;
        cnt = 0;
        while (!got && cnt < 3000) begin
            @(negedge clk);
            cnt++;
            got = tx_ready;
        end
        check("random_drains_to_idle", int'(got), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
